store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of the request and memory address buses.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  in  1  store request present.
REQ-005 Port: req_ready  out  1  unit idle and able to accept a request.
REQ-006 Port: funct3  in  3  store width: SB=000, SH=001, SW=010; all other codes are illegal.
REQ-007 Port: addr  in  ADDR_W  byte address of the store.
REQ-008 Port: wdata  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
REQ-009 Port: done  out  1  one-cycle pulse; request complete.
REQ-010 Port: err  out  1  one-cycle pulse, coincident with done, when a request is misaligned or illegal.
REQ-011 Port: mem_addr  out  ADDR_W  word address to memory: {addr[ADDR_W-1:2],2'b00}.
REQ-012 Port: mem_re  out  1  one-cycle word-read strobe.
REQ-013 Port: mem_rvalid  in  1  mem_rdata valid.
REQ-014 Port: mem_rdata  in  32  word read data.
REQ-015 Port: mem_we  out  1  word-write request; held high until acknowledged.
REQ-016 Port: mem_wdata  out  32  merged word to write.
REQ-017 Port: mem_wack  in  1  write acknowledge.

Function
REQ-018 Memory accepts whole 32-bit words only; the SHALL implement SB/SH stores by read-modify-write.
REQ-019 FSM states: IDLE, READ, WAIT_R, WRITE, DONE.
REQ-020 req_ready SHALL be 1 only in IDLE.
REQ-021 Acceptance happens when req_valid&&req_ready; funct3, addr and wdata SHALL be captured; later input changes SHALL have no effect.
REQ-022 Misalignment: SH with addr[0]=1, SW with addr[1:0]!=0, or an illegal funct3 SHALL go IDLE->DONE with err=1, and no mem_re/mem_we.
REQ-023 Aligned SW SHALL go IDLE->WRITE, with mem_wdata=wdata and no read.
REQ-024 Aligned SB/SH SHALL go IDLE->READ; READ asserts mem_re for exactly one cycle, then WAIT_R.
REQ-025 WAIT_R SHALL sample mem_rdata on the first cycle mem_rvalid=1, latch the merged word and go to WRITE; it SHALL wait indefinitely otherwise.
REQ-026 SB merge: byte lane addr[1:0] takes wdata[7:0]; the other three bytes come from mem_rdata.
REQ-027 SH merge: halfword lane addr[1] takes wdata[15:0]; the other half comes from mem_rdata.
REQ-028 WRITE SHALL hold mem_we=1 with stable mem_addr/mem_wdata until mem_wack=1 is sampled, then go to DONE.
REQ-029 mem_wack or mem_rvalid outside WRITE or WAIT_R respectively SHALL be ignored.
REQ-030 DONE SHALL assert done=1 (err per REQ-022) for one cycle, then go to IDLE.
REQ-031 Minimum latency, from acceptance edge to done: SW 2 cycles with immediate ack; SB/SH 4 cycles with rvalid and wack immediate.
REQ-032 mem_addr SHALL be held stable from READ through the write acknowledge.
REQ-033 Only one request SHALL be outstanding at a time; there is no pipelining.

Reset
REQ-034 While rst=1: state=IDLE; req_ready=1; done, err, mem_re and mem_we=0; mem_addr and mem_wdata=0; internal registers cleared.
REQ-035 Reset asserted mid-operation SHALL abort immediately; the in-flight store is dropped, with no done pulse and no further memory strobes.

Verification
REQ-036 SW addr=0x100, wdata=0xDEADBEEF, wack one cycle later -> no mem_re; mem_we with mem_addr=0x100, mem_wdata=0xDEADBEEF; done pulse, err=0.
REQ-037 SB addr=0x203, wdata=0x000000AB, rdata=0x11223344 -> mem_re once at 0x200; mem_wdata=0xAB223344; done.
REQ-038 SH addr=0x302, wdata=0x0000CAFE, rdata=0x11223344, rvalid delayed 3 cycles -> mem_wdata=0xCAFE3344; mem_we held until wack.
REQ-039 SW addr=0x101 and funct3=011 -> each gives done=1 and err=1, with zero mem_re/mem_we.
REQ-040 Assert rst during WAIT_R -> outputs at reset values; a subsequent SW completes normally.
REQ-041 Hold wack low for 10 cycles -> mem_we, mem_addr and mem_wdata stable throughout; req_ready=0 until after done.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit
//   Turns byte/halfword/word stores into whole-word memory writes. SW goes
//   straight to a word write. SB/SH read the target word, merge the new
//   byte/halfword into the correct lane, then write the merged word back.
//   Misaligned or illegal requests finish at once with err and do not touch
//   memory. Only one request is in flight at a time.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   funct3, addr, wdata store width code, byte address, right-justified data
//   done, err           one-cycle completion pulse, error flag with it
//   mem_addr            word-aligned address, held for the whole access
//   mem_re              one-cycle read strobe
//   mem_rvalid/mem_rdata read response
//   mem_we/mem_wdata    write request, held until mem_wack
//   mem_wack            write acknowledge
module store_merge_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT_R = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wd_q;   // only SB/SH data is needed after acceptance

  logic        bad_c;
  logic [31:0] merged_c;

  // Request is unusable: unknown width code or address not naturally aligned.
  always_comb begin
    bad_c = 1'b0;
    case (funct3)
      F3_SB:   bad_c = 1'b0;
      F3_SH:   bad_c = addr[0];
      F3_SW:   bad_c = (addr[1:0] != 2'b00);
      default: bad_c = 1'b1;
    endcase
  end

  // Insert the captured byte/halfword into the word just read.
  always_comb begin
    merged_c = mem_rdata;
    if (f3_q == F3_SB) begin
      merged_c[{lane_q, 3'b000} +: 8] = wd_q[7:0];
    end else if (lane_q[1]) begin
      merged_c[31:16] = wd_q;
    end else begin
      merged_c[15:0] = wd_q;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      wd_q      <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q      <= funct3;
            lane_q    <= addr[1:0];
            wd_q      <= wdata[15:0];
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            req_ready <= 1'b0;
            if (bad_c) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (funct3 == F3_SW) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WAIT_R;
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            mem_wdata <= merged_c;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (mem_wack) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: drives requests and a simple memory
// responder on the falling edge, checks outputs on the falling edge.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_wack;

  int n_checks = 0;
  int n_fail   = 0;

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .done       (done),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full request with a scripted memory: rlat extra cycles before rvalid,
  // wlat cycles of mem_we before wack. Inputs are scrambled after acceptance.
  task automatic run_store(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int rlat, input int wlat,
                           input logic exp_err, input logic [31:0] exp_wd,
                           input int exp_re, input int exp_lat);
    int n_re, n_we, rd_cnt, lat, exp_we;
    logic pend, got_done;
    logic [31:0] exp_ma;
    exp_ma = {a[31:2], 2'b00};
    exp_we = exp_err ? 0 : wlat + 1;
    n_re = 0; n_we = 0; rd_cnt = 0; lat = 0; pend = 1'b0; got_done = 1'b0;

    @(negedge clk);
    check({tag, ":ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; funct3 = 3'b111; addr = ~a; wdata = ~wd;

    for (int k = 1; k <= 100 && !got_done; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0; mem_wack = 1'b0; mem_rdata = '0;
      if (mem_re) begin
        n_re++;
        check({tag, ":re_addr"}, mem_addr, exp_ma);
        pend = 1'b1; rd_cnt = rlat;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;   // must be ignored in READ
      end else if (pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rd; pend = 1'b0;
        end else begin
          rd_cnt--;
          mem_wack = 1'b1;                               // must be ignored in WAIT_R
        end
      end
      if (mem_we) begin
        n_we++;
        check({tag, ":we_addr"}, mem_addr, exp_ma);
        check({tag, ":we_data"}, mem_wdata, exp_wd);
        if (n_we == wlat + 1) mem_wack = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        lat = k;
        check({tag, ":err"}, 32'(err), 32'(exp_err));
      end else begin
        check({tag, ":busy_ready"}, 32'(req_ready), 32'd0);
      end
    end
    mem_rvalid = 1'b0; mem_wack = 1'b0;

    check({tag, ":done_seen"}, 32'(got_done), 32'd1);
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":re_count"}, 32'(n_re), 32'(exp_re));
    check({tag, ":we_cycles"}, 32'(n_we), 32'(exp_we));

    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
    check({tag, ":err_pulse"}, 32'(err), 32'd0);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":err"}, 32'(err), 32'd0);
    check({tag, ":re"}, 32'(mem_re), 32'd0);
    check({tag, ":we"}, 32'(mem_we), 32'd0);
    check({tag, ":addr"}, mem_addr, 32'd0);
    check({tag, ":wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_wack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    //        tag        f3      addr          wdata         rdata         rl wl err exp_wdata     re lat
    run_store("sw_basic", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1, 0, 32'hDEAD_BEEF, 0, 3);
    run_store("sw_fast",  3'b010, 32'h0000_0104, 32'h0BAD_F00D, 32'h0,        0, 0, 0, 32'h0BAD_F00D, 0, 2);
    run_store("sb_l3",    3'b000, 32'h0000_0203, 32'h0000_00AB, 32'h1122_3344, 0, 0, 0, 32'hAB22_3344, 1, 4);
    run_store("sh_hi",    3'b001, 32'h0000_0302, 32'h0000_CAFE, 32'h1122_3344, 3, 2, 0, 32'hCAFE_3344, 1, 9);
    run_store("sb_l0",    3'b000, 32'h0000_0200, 32'h0000_0055, 32'h1122_3344, 0, 0, 0, 32'h1122_3355, 1, 4);
    run_store("sb_l1",    3'b000, 32'h0000_0201, 32'h0000_0066, 32'h1122_3344, 1, 0, 0, 32'h1122_6644, 1, 5);
    run_store("sb_l2",    3'b000, 32'h0000_0202, 32'hFFFF_FFAA, 32'h1122_3344, 0, 0, 0, 32'h11AA_3344, 1, 4);
    run_store("sh_lo",    3'b001, 32'h0000_0300, 32'hFFFF_BEEF, 32'h1122_3344, 0, 1, 0, 32'h1122_BEEF, 1, 5);
    run_store("sw_mis",   3'b010, 32'h0000_0101, 32'h1234_5678, 32'h0,        0, 0, 1, 32'h0,        0, 1);
    run_store("sw_mis2",  3'b010, 32'h0000_0102, 32'h1234_5678, 32'h0,        0, 0, 1, 32'h0,        0, 1);
    run_store("f3_ill",   3'b011, 32'h0000_0100, 32'h1234_5678, 32'h0,        0, 0, 1, 32'h0,        0, 1);
    run_store("sh_mis",   3'b001, 32'h0000_0301, 32'h0000_CAFE, 32'h0,        0, 0, 1, 32'h0,        0, 1);
    run_store("sw_slow",  3'b010, 32'h0000_0400, 32'h1234_5678, 32'h0,        0, 10, 0, 32'h1234_5678, 0, 12);

    // Reset while waiting for read data: store is dropped.
    @(negedge clk);
    req_valid = 1'b1; funct3 = 3'b000; addr = 32'h0000_0500; wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort:re_seen", 32'(mem_re), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555; mem_wack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort:no_done", 32'(done), 32'd0);
      check("abort:no_strobe", 32'({mem_re, mem_we}), 32'd0);
    end
    mem_rvalid = 1'b0; mem_wack = 1'b0;
    run_store("sw_post",  3'b010, 32'h0000_0600, 32'hA5A5_5A5A, 32'h0,        0, 0, 0, 32'hA5A5_5A5A, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
